// File: rtl/serial_sub_pkg.sv
// Shared types and limits for the bit-serial subtractor controller.
// Holds the FSM state encoding and the legal WIDTH range.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/serial_subtractor_ctrl_if.sv
// Start/result handshake bundle between a requester and the serial subtractor.
// The requester takes the master side; the subtractor takes the slave side.
interface serial_subtractor_ctrl_if #(parameter int WIDTH = 8);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             zero;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout, zero
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout, zero
    );

endinterface

// File: rtl/serial_subtractor_ctrl_fs_bit.sv
// Combinational 1-bit full-subtractor cell: d = a - b - bin, with borrow-out.
module fs_bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (bin & ~(a ^ b));

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial subtractor: one fs_bit cell reused over WIDTH cycles, LSB first.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | waiting for start; operands captured on the accepting edge
// ST_RUN  | one bit per edge through the cell, cnt counts 0..WIDTH-1
// ST_DONE | result registered, done pulse high for this cycle
module serial_subtractor_ctrl
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    serial_subtractor_ctrl_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("serial_subtractor_ctrl: WIDTH outside legal range");
    end

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] sd_q, sd_d;
    logic             brw_q, brw_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;

    logic             cell_d;
    logic             cell_bo;
    logic [WIDTH-1:0] sd_next;

    fs_bit u_cell (
        .a    (sa_q[0]),
        .b    (sb_q[0]),
        .bin  (brw_q),
        .d    (cell_d),
        .bout (cell_bo)
    );

    // New difference bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
    assign sd_next = {cell_d, sd_q[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sa_q    <= '0;
            sb_q    <= '0;
            sd_q    <= '0;
            brw_q   <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            zero_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sd_q    <= sd_d;
            brw_q   <= brw_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        sd_d    = sd_q;
        brw_d   = brw_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        zero_d  = zero_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    sa_d    = bus.a;
                    sb_d    = bus.b;
                    brw_d   = bus.bin;
                    cnt_d   = '0;
                    sd_d    = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                sd_d  = sd_next;
                brw_d = cell_bo;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    diff_d  = sd_next;
                    bout_d  = cell_bo;
                    zero_d  = (sd_next == '0);
                    done_d  = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.busy = (state_q != ST_IDLE);
    assign bus.done = done_q;
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
    assign bus.zero = zero_q;

endmodule

// File: doc/serial_subtractor_ctrl.md
# serial_subtractor_ctrl

Bit-serial multi-bit subtractor that time-shares one 1-bit full-subtractor cell across WIDTH cycles, LSB first, computing a − b − bin. It owns the operand shift registers, the borrow flip-flop, the bit counter and the start/done handshake. It is the sequencing layer above the combinational borrow cell, for area-constrained paths where a ripple subtractor of full width is not wanted.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; accepted only on an edge where the FSM is in IDLE.
- a  input  WIDTH  minuend; sampled on the accepting edge only.
- b  input  WIDTH  subtrahend; sampled on the accepting edge only.
- bin  input  1  initial borrow-in; sampled on the accepting edge only.
- busy  output  1  high whenever the state is not IDLE.
- done  output  1  one-cycle pulse; result is valid.
- diff  output  WIDTH  registered difference; held until the next completion.
- bout  output  1  registered final borrow-out; held until the next completion.
- zero  output  1  registered (diff == 0); updated together with diff.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN when start = 1.
  - RUN → DONE on the edge where cnt = WIDTH−1.
  - DONE → IDLE unconditionally.
- Accept edge (IDLE and start = 1):
  - sa ← a, sb ← b, brw ← bin, cnt ← 0.
  - sd (internal difference shift register) ← 0.
- Per RUN edge, the cell computes from sa[0], sb[0] and brw:
  - d = sa[0] ^ sb[0] ^ brw
  - bo = (~sa[0] & sb[0]) | (brw & ~(sa[0] ^ sb[0]))
- Per RUN edge, register updates:
  - sa, sb shift right by one, zero fill.
  - sd shifts right with d entering at bit WIDTH−1.
  - brw ← bo; cnt ← cnt + 1.
- On the RUN → DONE edge:
  - diff ← final shifted value; bout ← bo; zero ← (final diff == 0).
  - diff, bout and zero do not change at any other time.
- cnt width is $clog2(WIDTH), so no wrap occurs before the exit compare.
- start while busy = 1 (RUN or DONE) is ignored and not queued.
- Arithmetic: {bout, diff} = a − b − bin, modulo 2^(WIDTH+1), with bout = 1 exactly when a < b + bin (unsigned).

## Timing
- Reset values: state IDLE, busy 0, done 0, diff 0, bout 0, zero 1; all internal registers 0.
- Reset is asynchronous and takes effect mid-RUN or in DONE. The aborted operation produces no done and its result is lost.
- Latency: with the accepting edge as E0, edges E1..EWIDTH process bits 0..WIDTH−1. done is high from EWIDTH to EWIDTH+1.
- busy is high from E0 to EWIDTH+1, which is WIDTH+1 cycles.
- Throughput: one operation per WIDTH+2 cycles. The earliest next accept is EWIDTH+2, with start held high.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package serial_sub_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - the WIDTH legality check constants.
- One sub-module, fs_bit: the combinational 1-bit borrow cell (a, b, bin → d, bout), instantiated once.
- The controller holds the FSM, counter, shift registers and output registers.

## Test plan
- a = 0x5A, b = 0x3C, bin = 0 → done at E8; diff 0x1E, bout 0, zero 0; busy high for 9 cycles.
- a = 0x00, b = 0x01, bin = 0 → diff 0xFF, bout 1. Then a = 0x00, b = 0x00, bin = 1 → diff 0xFF, bout 1.
- a = 0xFF, b = 0xFF, bin = 0 → diff 0x00, bout 0, zero 1. Previous diff/bout remain stable throughout RUN.
- start pulsed at E3 and at E8 (DONE) of a running operation → both ignored; exactly one done. A start held high is accepted at E10.
- rst asserted asynchronously at mid-RUN E4 → busy, done, diff and bout go to 0 immediately, zero goes to 1; no done follows. A new start completes correctly.
- Randomised 500 operations at WIDTH = 8 and 13 → {bout, diff} matches a − b − bin; no done with busy low.
